// File: rtl/mc_control_unit.sv
// Multicycle RV64I control FSM: decodes opcode/funct fields and drives datapath
// enables and mux selects, with configurable memory wait states, trap and halt.
module mc_control_unit #(
  parameter int unsigned MEM_WAIT     = 1,
  parameter bit          ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       resume,
  output logic [4:0] state_out,
  output logic       ir_load,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       load_a,
  output logic       load_b,
  output logic       load_aout,
  output logic       load_mdr,
  output logic [3:0] pc_wr_cond,
  output logic [1:0] pc_source,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_fct,
  output logic [2:0] mem_to_reg,
  output logic [1:0] shift,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [4:0] {
    S_RST    = 5'd0,  S_FETCH = 5'd1,  S_FWAIT = 5'd2,  S_DECODE = 5'd3,
    S_ADDR   = 5'd4,  S_MRD   = 5'd5,  S_MWB   = 5'd6,  S_MWR    = 5'd7,
    S_EXR    = 5'd8,  S_EXI   = 5'd9,  S_WBALU = 5'd10, S_BRANCH = 5'd11,
    S_LUI    = 5'd12, S_SHIFT = 5'd13, S_SLT   = 5'd14, S_JAL    = 5'd15,
    S_JALR   = 5'd16, S_TRAP  = 5'd17, S_HALT  = 5'd18
  } state_t;

  localparam logic [2:0] FCT_ADD = 3'b001;
  localparam logic [2:0] FCT_SUB = 3'b010;
  localparam logic [2:0] FCT_AND = 3'b011;
  localparam logic [2:0] FCT_CMP = 3'b111;
  // A zero-wait memory still needs one MRD cycle to latch the data.
  localparam logic [3:0] LAST = (MEM_WAIT == 0) ? 4'd0 : 4'(MEM_WAIT - 1);

  state_t     state, next_state, dispatch;
  logic [3:0] wait_cnt;
  logic       wait_done;

  assign wait_done = (wait_cnt == LAST);
  assign state_out = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_RST;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == S_FWAIT || state == S_MRD) wait_cnt <= wait_cnt + 4'd1;
      else                                    wait_cnt <= '0;
    end
  end

  always_comb begin
    dispatch = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000 && funct3 == 3'b010) dispatch = S_SLT;
        else if ((funct7 == 7'b0000000 && (funct3 == 3'b000 || funct3 == 3'b111)) ||
                 (funct7 == 7'b0100000 && funct3 == 3'b000)) dispatch = S_EXR;
      end
      7'b0010011: begin
        case (funct3)
          3'b000:         dispatch = S_EXI;
          3'b010:         dispatch = S_SLT;
          3'b001, 3'b101: dispatch = S_SHIFT;
          default:        ;
        endcase
      end
      7'b0000011: if (funct3 == 3'b011) dispatch = S_ADDR;
      7'b0100011: if (funct3 == 3'b111) dispatch = S_ADDR;
      7'b1100011: begin
        if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b101)
          dispatch = S_BRANCH;
      end
      7'b1100111: if (funct3 == 3'b000) dispatch = S_JALR;
      7'b1101111: dispatch = S_JAL;
      7'b0110111: dispatch = S_LUI;
      7'b1110011: dispatch = S_HALT;
      default:    ;
    endcase
  end

  always_comb begin
    next_state = S_RST;
    case (state)
      S_RST:    next_state = S_FETCH;
      S_FETCH:  next_state = (MEM_WAIT == 0) ? S_DECODE : S_FWAIT;
      S_FWAIT:  next_state = wait_done ? S_DECODE : S_FWAIT;
      S_DECODE: next_state = dispatch;
      S_ADDR:   next_state = (opcode == 7'b0000011) ? S_MRD : S_MWR;
      S_MRD:    next_state = wait_done ? S_MWB : S_MRD;
      S_EXR, S_EXI: next_state = S_WBALU;
      S_MWB, S_MWR, S_WBALU, S_BRANCH, S_LUI, S_SHIFT, S_SLT, S_JAL, S_JALR:
                next_state = S_FETCH;
      S_TRAP:   next_state = S_TRAP;
      S_HALT:   next_state = resume ? S_FETCH : S_HALT;
      default:  next_state = S_RST;
    endcase
  end

  always_comb begin
    ir_load = 1'b0; pc_write = 1'b0; reg_write = 1'b0; mem_write = 1'b0;
    load_a = 1'b0; load_b = 1'b0; load_aout = 1'b0; load_mdr = 1'b0;
    pc_wr_cond = '0; pc_source = '0; alu_src_a = '0; alu_src_b = '0;
    alu_fct = '0; mem_to_reg = '0; shift = '0; halted = 1'b0; illegal = 1'b0;
    case (state)
      // Without a wait state the fetch completes in FETCH itself.
      S_FETCH, S_FWAIT: begin
        if ((state == S_FETCH && MEM_WAIT == 0) || (state == S_FWAIT && wait_done)) begin
          ir_load = 1'b1; pc_write = 1'b1; alu_src_b = 2'd1; alu_fct = FCT_ADD;
        end
      end
      S_DECODE: begin
        load_a = 1'b1; load_b = 1'b1; load_aout = 1'b1;
        alu_src_b = 2'd3; alu_fct = FCT_ADD;
      end
      S_ADDR: begin
        alu_src_a = 2'd1; alu_src_b = 2'd2; alu_fct = FCT_ADD; load_aout = 1'b1;
      end
      S_MRD: load_mdr = wait_done;
      S_MWB: begin reg_write = 1'b1; mem_to_reg = 3'd1; end
      S_MWR: mem_write = 1'b1;
      S_EXR: begin
        alu_src_a = 2'd1; load_aout = 1'b1;
        if (funct3 == 3'b111) alu_fct = FCT_AND;
        else if (funct7[5])   alu_fct = FCT_SUB;
        else                  alu_fct = FCT_ADD;
      end
      S_EXI: begin
        alu_src_a = 2'd1; alu_src_b = 2'd2; alu_fct = FCT_ADD; load_aout = 1'b1;
      end
      S_WBALU: reg_write = 1'b1;
      S_SLT: begin
        alu_src_a = 2'd1; alu_src_b = (opcode == 7'b0010011) ? 2'd2 : 2'd0;
        alu_fct = FCT_CMP; reg_write = 1'b1; mem_to_reg = 3'd5;
      end
      S_SHIFT: begin
        reg_write = 1'b1; mem_to_reg = 3'd3;
        if (funct3 == 3'b001)  shift = 2'b00;
        else if (funct7[5])    shift = 2'b10;
        else                   shift = 2'b01;
      end
      S_LUI: begin reg_write = 1'b1; mem_to_reg = 3'd2; end
      S_BRANCH: begin
        alu_src_a = 2'd1; pc_source = 2'd1;
        alu_fct = funct3[2] ? FCT_CMP : FCT_SUB;
        case (funct3)
          3'b000:  pc_wr_cond = 4'b0001;
          3'b001:  pc_wr_cond = 4'b0010;
          3'b101:  pc_wr_cond = 4'b0100;
          3'b100:  pc_wr_cond = 4'b1000;
          default: pc_wr_cond = 4'b0000;
        endcase
      end
      S_JAL: begin
        reg_write = 1'b1; mem_to_reg = 3'd4; pc_write = 1'b1; pc_source = 2'd1;
      end
      S_JALR: begin
        reg_write = 1'b1; mem_to_reg = 3'd4; pc_write = 1'b1; pc_source = 2'd2;
        alu_src_a = 2'd1; alu_src_b = 2'd2; alu_fct = FCT_ADD;
      end
      S_TRAP: illegal = 1'b1;
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: three instances cover MEM_WAIT=1/3 and
// both illegal-instruction policies.
module tb_mc_control_unit;

  typedef struct packed {
    logic [4:0] state;
    logic [7:0] en;      // {ir_load,pc_write,reg_write,mem_write,load_a,load_b,load_aout,load_mdr}
    logic [3:0] cond;
    logic [1:0] pcs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] fct;
    logic [2:0] m2r;
    logic [1:0] sh;
    logic       halted;
    logic       illegal;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       resume = 1'b0;
  wire obs_t  o1, o3, on;
  int unsigned total = 0;
  int unsigned bad = 0;

  always #5 clk = ~clk;

  mc_control_unit #(.MEM_WAIT(1), .ILLEGAL_TRAP(1'b1)) u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .resume(resume), .state_out(o1.state),
    .ir_load(o1.en[7]), .pc_write(o1.en[6]), .reg_write(o1.en[5]), .mem_write(o1.en[4]),
    .load_a(o1.en[3]), .load_b(o1.en[2]), .load_aout(o1.en[1]), .load_mdr(o1.en[0]),
    .pc_wr_cond(o1.cond), .pc_source(o1.pcs), .alu_src_a(o1.sa), .alu_src_b(o1.sb),
    .alu_fct(o1.fct), .mem_to_reg(o1.m2r), .shift(o1.sh), .halted(o1.halted),
    .illegal(o1.illegal)
  );

  mc_control_unit #(.MEM_WAIT(3), .ILLEGAL_TRAP(1'b1)) u_dut_w3 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .resume(resume), .state_out(o3.state),
    .ir_load(o3.en[7]), .pc_write(o3.en[6]), .reg_write(o3.en[5]), .mem_write(o3.en[4]),
    .load_a(o3.en[3]), .load_b(o3.en[2]), .load_aout(o3.en[1]), .load_mdr(o3.en[0]),
    .pc_wr_cond(o3.cond), .pc_source(o3.pcs), .alu_src_a(o3.sa), .alu_src_b(o3.sb),
    .alu_fct(o3.fct), .mem_to_reg(o3.m2r), .shift(o3.sh), .halted(o3.halted),
    .illegal(o3.illegal)
  );

  mc_control_unit #(.MEM_WAIT(1), .ILLEGAL_TRAP(1'b0)) u_dut_nt (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .resume(resume), .state_out(on.state),
    .ir_load(on.en[7]), .pc_write(on.en[6]), .reg_write(on.en[5]), .mem_write(on.en[4]),
    .load_a(on.en[3]), .load_b(on.en[2]), .load_aout(on.en[1]), .load_mdr(on.en[0]),
    .pc_wr_cond(on.cond), .pc_source(on.pcs), .alu_src_a(on.sa), .alu_src_b(on.sb),
    .alu_fct(on.fct), .mem_to_reg(on.m2r), .shift(on.sh), .halted(on.halted),
    .illegal(on.illegal)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Drives one instruction through FETCH/FWAIT/DECODE on the MEM_WAIT=1 instance
  // and leaves it in the first execute state.
  task automatic to_exec(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7);
    opcode = op; funct3 = f3; funct7 = f7;
    step(); chk({tag, "_fetch"}, o1.state, 5'd1);
    step(); chk({tag, "_fwait"}, o1.state, 5'd2);
    chk({tag, "_fwait_en"}, o1.en, 8'b1100_0000);
    step(); chk({tag, "_decode"}, o1.state, 5'd3);
    chk({tag, "_decode_en"}, o1.en, 8'b0000_1110);
    step();
  endtask

  initial begin
    // reset state, all outputs low
    step();
    chk("rst_all", o1, '0);
    chk("rst_all_w3", o3, '0);
    chk("rst_all_nt", on, '0);

    // ld up to MRD, then asynchronous reset mid-instruction
    reset = 1'b0;
    to_exec("ld1", 7'b0000011, 3'b011, 7'd0);
    chk("ld1_addr", o1.state, 5'd4);
    chk("ld1_addr_sb", o1.sb, 2'd2);
    step(); chk("ld1_mrd", o1.state, 5'd5);
    chk("ld1_mdr", o1.en, 8'b0000_0001);
    reset = 1'b1; #1;
    chk("async_rst", o1, '0);
    reset = 1'b0;

    // add x3,x1,x2
    to_exec("add", 7'b0110011, 3'b000, 7'b0000000);
    chk("add_exr", o1.state, 5'd8);
    chk("add_fct", o1.fct, 3'b001);
    chk("add_exr_en", o1.en, 8'b0000_0010);
    chk("add_exr_sa", o1.sa, 2'd1);
    step(); chk("add_wb", o1.state, 5'd10);
    chk("add_wb_en", o1.en, 8'b0010_0000);
    chk("add_wb_m2r", o1.m2r, 3'd0);

    to_exec("bge", 7'b1100011, 3'b101, 7'd0);
    chk("bge_state", o1.state, 5'd11);
    chk("bge_cond", o1.cond, 4'b0100);
    chk("bge_fct", o1.fct, 3'b111);
    chk("bge_pcs", o1.pcs, 2'd1);
    to_exec("blt", 7'b1100011, 3'b100, 7'd0);
    chk("blt_cond", o1.cond, 4'b1000);
    to_exec("beq", 7'b1100011, 3'b000, 7'd0);
    chk("beq_cond", o1.cond, 4'b0001);
    chk("beq_fct", o1.fct, 3'b010);

    to_exec("jalr", 7'b1100111, 3'b000, 7'd0);
    chk("jalr_state", o1.state, 5'd16);
    chk("jalr_pcs", o1.pcs, 2'd2);
    chk("jalr_m2r", o1.m2r, 3'd4);
    chk("jalr_en", o1.en, 8'b0110_0000);
    chk("jalr_sb", o1.sb, 2'd2);

    to_exec("sub", 7'b0110011, 3'b000, 7'b0100000);
    chk("sub_fct", o1.fct, 3'b010);
    step();
    to_exec("sra", 7'b0010011, 3'b101, 7'b0100000);
    chk("sra_state", o1.state, 5'd13);
    chk("sra_shift", o1.sh, 2'b10);
    to_exec("slti", 7'b0010011, 3'b010, 7'd0);
    chk("slti_state", o1.state, 5'd14);
    chk("slti_sb", o1.sb, 2'd2);
    chk("slti_m2r", o1.m2r, 3'd5);
    to_exec("lui", 7'b0110111, 3'b000, 7'd0);
    chk("lui_m2r", o1.m2r, 3'd2);

    // ebreak: halt, hold, resume
    to_exec("ebrk", 7'b1110011, 3'b000, 7'd0);
    chk("halt_state", o1.state, 5'd18);
    chk("halt_flag", o1.halted, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("halt_hold", {o1.state, o1.halted}, {5'd18, 1'b1});
    end
    resume = 1'b1; step(); resume = 1'b0;
    chk("resume_fetch", o1.state, 5'd1);
    chk("resume_flag", o1.halted, 1'b0);

    // illegal opcode under both policies
    do_reset();
    to_exec("ill", 7'b0001111, 3'b000, 7'd0);
    chk("trap_state", o1.state, 5'd17);
    chk("trap_flag", o1.illegal, 1'b1);
    chk("notrap_state", on.state, 5'd1);
    chk("notrap_en", on.en, 8'd0);
    chk("notrap_flag", on.illegal, 1'b0);
    resume = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("trap_hold", {o1.state, o1.illegal}, {5'd17, 1'b1});
    end
    resume = 1'b0;

    // MEM_WAIT=3 load
    opcode = 7'b0000011; funct3 = 3'b011; funct7 = '0;
    do_reset();
    step(); chk("w3_fetch", o3.state, 5'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("w3_fwait", o3.state, 5'd2);
      chk("w3_ir_load", o3.en[7], (k == 2));
    end
    step(); chk("w3_decode", o3.state, 5'd3);
    step(); chk("w3_addr", o3.state, 5'd4);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("w3_mrd", o3.state, 5'd5);
      chk("w3_load_mdr", o3.en[0], (k == 2));
    end
    step(); chk("w3_mwb", o3.state, 5'd6);
    chk("w3_mwb_en", o3.en, 8'b0010_0000);
    chk("w3_mwb_m2r", o3.m2r, 3'd1);
    step(); chk("w3_back", o3.state, 5'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
